// File: rtl/status_pkg.sv
// Shared constants and types for the status register stack.
package status_pkg;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  localparam int unsigned NFLAGS_DEF = 4;
  localparam int unsigned DEPTH_DEF  = 4;

  typedef logic [NFLAGS_DEF-1:0] flag_word_t;

endpackage

// File: rtl/flag_lifo.sv
// LIFO shadow stack for flag words: storage, occupancy level, full/empty decode and
// registered error pulse. Exposes the top entry and push/pop accept strobes.
module flag_lifo
  import status_pkg::*;
#(
  parameter int unsigned Width = NFLAGS_DEF,
  parameter int unsigned Depth = DEPTH_DEF,
  localparam int unsigned LvlW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] top,
  output logic [LvlW-1:0]  level,
  output logic             full,
  output logic             empty,
  output logic             err,
  output logic             push_acc,
  output logic             pop_acc
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [LvlW-1:0]  level_q, level_d;
  logic [LvlW-1:0]  top_idx;
  logic             err_q, err_d;

  assign full  = (level_q == LvlW'(Depth));
  assign empty = (level_q == '0);

  // Simultaneous push and pop is illegal and leaves the stack untouched.
  assign push_acc = push & ~pop & ~full;
  assign pop_acc  = pop & ~push & ~empty;

  assign top_idx = level_q - LvlW'(1);
  assign top     = mem_q[top_idx[AddrW-1:0]];

  always_comb begin
    level_d = level_q;
    if (push_acc) begin
      level_d = level_q + LvlW'(1);
    end else if (pop_acc) begin
      level_d = level_q - LvlW'(1);
    end
    err_d = (push & pop) | (push & full) | (pop & empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset; entries are only visible once rewritten.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      mem_q[level_q[AddrW-1:0]] <= wdata;
    end
  end

  assign level = level_q;
  assign err   = err_q;

endmodule

// File: rtl/status_register_stack.sv
// Masked-load condition flag register with LIFO shadow stack.
// Optional sticky V accumulator enabled by STATUS_STICKY_EN.
module status_register_stack
  import status_pkg::*;
#(
  parameter int unsigned NFLAGS = NFLAGS_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned LvlW  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [NFLAGS-1:0] mask,
  input  logic [NFLAGS-1:0] flags_in,
  input  logic              push,
  input  logic              pop,
  input  logic              sticky_clr,
  output logic [NFLAGS-1:0] out,
  output logic              sticky,
  output logic [LvlW-1:0]   level,
  output logic              empty,
  output logic              full,
  output logic              err
);

  logic [NFLAGS-1:0] out_q, out_d;
  logic [NFLAGS-1:0] top;
  logic              push_acc, pop_acc;
  logic              load_wr;

  flag_lifo #(
    .Width (NFLAGS),
    .Depth (DEPTH)
  ) u_lifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wdata    (out_q),
    .top      (top),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .err      (err),
    .push_acc (push_acc),
    .pop_acc  (pop_acc)
  );

  // A load is dropped when a pop wins or when push and pop collide.
  assign load_wr = load & ~pop_acc & ~(push & pop);

  always_comb begin
    out_d = out_q;
    if (pop_acc) begin
      out_d = top;
    end else if (load_wr) begin
      out_d = (out_q & ~mask) | (flags_in & mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

`ifdef STATUS_STICKY_EN
  logic sticky_q;

  // Set on a 0->1 transition of V; clear takes precedence.
  always_ff @(posedge clk) begin
    if (rst || sticky_clr) begin
      sticky_q <= 1'b0;
    end else if (out_d[FLAG_V] && !out_q[FLAG_V]) begin
      sticky_q <= 1'b1;
    end
  end

  assign sticky = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky            = 1'b0;
`endif

endmodule

// File: tb/tb_status_register_stack.sv
// Self-checking bench for status_register_stack: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_status_register_stack;

  localparam int NF = 4;
  localparam int DP = 4;
  localparam int LW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst, load, push, pop, sticky_clr;
  logic [NF-1:0] mask, flags_in, out;
  logic          sticky, empty, full, err;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [NF-1:0] m_out = '0;
  logic [NF-1:0] m_q[$];
  logic          m_err = 1'b0;
  logic          m_sticky = 1'b0;

  always #5 clk = ~clk;

  status_register_stack #(
    .NFLAGS (NF),
    .DEPTH  (DP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .mask       (mask),
    .flags_in   (flags_in),
    .push       (push),
    .pop        (pop),
    .sticky_clr (sticky_clr),
    .out        (out),
    .sticky     (sticky),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .err        (err)
  );

  // Drive one cycle of inputs, advance the model, and return 1 ns after the edge.
  task automatic step(input logic r, input logic ld, input logic [NF-1:0] mk,
                      input logic [NF-1:0] fi, input logic pu, input logic po,
                      input logic sc);
    logic [NF-1:0] nxt;
    logic [NF-1:0] loaded;
    rst = r; load = ld; mask = mk; flags_in = fi; push = pu; pop = po; sticky_clr = sc;
    loaded = (m_out & ~mk) | (fi & mk);
    nxt    = m_out;
    m_err  = 1'b0;
    if (r) begin
      nxt = '0;
      m_q.delete();
    end else if (pu && po) begin
      m_err = 1'b1;
    end else if (po) begin
      if (m_q.size() == 0) begin
        m_err = 1'b1;
        if (ld) nxt = loaded;
      end else begin
        nxt = m_q.pop_back();
      end
    end else begin
      if (pu) begin
        if (m_q.size() == DP) m_err = 1'b1;
        else m_q.push_back(m_out);
      end
      if (ld) nxt = loaded;
    end
`ifdef STATUS_STICKY_EN
    if (r || sc) m_sticky = 1'b0;
    else if (nxt[3] && !m_out[3]) m_sticky = 1'b1;
`else
    m_sticky = 1'b0;
`endif
    m_out = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (out !== 4'b0000) begin errors++; $display("FAIL reset_out: got %b want 0000", out); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got %b%b want 10", empty, full); end
    checks++; if (err !== 1'b0 || sticky !== 1'b0) begin errors++; $display("FAIL reset_err_sticky: got %b%b want 00", err, sticky); end
  endtask

  task automatic test_load();
    step(1'b0, 1'b1, 4'b1111, 4'b1010, 1'b0, 1'b0, 1'b0);
    checks++; if (out !== 4'b1010) begin errors++; $display("FAIL load_full_mask: got %b want 1010", out); end
    step(1'b0, 1'b1, 4'b0001, 4'b0101, 1'b0, 1'b0, 1'b0);
    checks++; if (out !== 4'b1011) begin errors++; $display("FAIL load_partial_mask: got %b want 1011", out); end
    step(1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);
    checks++; if (out !== 4'b1011) begin errors++; $display("FAIL load_zero_mask: got %b want 1011", out); end
  endtask

  task automatic test_push_load_pop();
    step(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0);
    checks++; if (out !== 4'b0001 || level !== 3'd1) begin errors++; $display("FAIL push_with_load: got out=%b level=%0d want 0001/1", out, level); end
    step(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0);
    checks++; if (out !== 4'b1011 || level !== 3'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL pop_restore: got out=%b level=%0d empty=%b want 1011/0/1", out, level, empty);
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL pop_restore_err: got %b want 0", err); end
  endtask

  task automatic test_full();
    logic [NF-1:0] words [DP];
    for (int i = 0; i < DP; i++) begin
      words[i] = m_out;
      step(1'b0, 1'b1, 4'b1111, 4'(i + 3), 1'b1, 1'b0, 1'b0);
    end
    checks++; if (full !== 1'b1 || level !== 3'd4) begin errors++; $display("FAIL fill: got full=%b level=%0d want 1/4", full, level); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (err !== 1'b1 || level !== 3'd4) begin errors++; $display("FAIL push_full: got err=%b level=%0d want 1/4", err, level); end
    idle();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b want 0", err); end
    for (int i = DP - 1; i >= 0; i--) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      checks++; if (out !== words[i]) begin errors++; $display("FAIL pop_order_%0d: got %b want %b", i, out, words[i]); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drained: got empty=%b want 1", empty); end
  endtask

  task automatic test_illegal();
    step(1'b0, 1'b1, 4'b1111, 4'b0100, 1'b0, 1'b1, 1'b0);
    checks++; if (err !== 1'b1 || out !== 4'b0100) begin errors++; $display("FAIL pop_empty: got err=%b out=%b want 1/0100", err, out); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 4'b1001, 1'b1, 1'b1, 1'b0);
    checks++; if (err !== 1'b1 || out !== 4'b0100 || level !== 3'd1) begin
      errors++; $display("FAIL push_pop_same: got err=%b out=%b level=%0d want 1/0100/1", err, out, level);
    end
  endtask

  task automatic test_rst_mid();
    step(1'b0, 1'b1, 4'b1111, 4'b0110, 1'b1, 1'b0, 1'b0);
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL pre_rst_level: got %0d want 2", level); end
    step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
    checks++; if (level !== 3'd0 || out !== 4'b0000 || err !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL rst_mid_push: got level=%0d out=%b err=%b empty=%b want 0/0000/0/1", level, out, err, empty);
    end
  endtask

  task automatic test_sticky();
`ifdef STATUS_STICKY_EN
    step(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
    checks++; if (sticky !== 1'b1) begin errors++; $display("FAIL sticky_hold: got %b want 1", sticky); end
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    checks++; if (sticky !== 1'b0) begin errors++; $display("FAIL sticky_clr: got %b want 0", sticky); end
    step(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1);
    checks++; if (sticky !== 1'b0) begin errors++; $display("FAIL sticky_clr_wins: got %b want 0", sticky); end
`else
    step(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
    checks++; if (sticky !== 1'b0) begin errors++; $display("FAIL sticky_tied: got %b want 0", sticky); end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic r, pu, po;
      r  = ($urandom_range(0, 49) == 0);
      pu = ($urandom_range(0, 9) < 5);
      po = ($urandom_range(0, 9) < 4);
      step(r, 1'($urandom), 4'($urandom), 4'($urandom), pu, po, ($urandom_range(0, 7) == 0));
      checks++; if (out !== m_out) begin errors++; $display("FAIL rnd_out[%0d]: got %b want %b", n, out, m_out); end
      checks++; if (level !== LW'(m_q.size())) begin errors++; $display("FAIL rnd_level[%0d]: got %0d want %0d", n, level, m_q.size()); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b want %b", n, err, m_err); end
      checks++; if (empty !== (m_q.size() == 0) || full !== (m_q.size() == DP)) begin
        errors++; $display("FAIL rnd_flags[%0d]: got empty=%b full=%b size=%0d", n, empty, full, m_q.size());
      end
      checks++; if (sticky !== m_sticky) begin errors++; $display("FAIL rnd_sticky[%0d]: got %b want %b", n, sticky, m_sticky); end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; mask = '0; flags_in = '0;
    push = 1'b0; pop = 1'b0; sticky_clr = 1'b0;
    test_reset();
    test_load();
    test_push_load_pop();
    test_full();
    test_illegal();
    test_rst_mid();
    test_sticky();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
